audio_write_arbiter: RTL and testbench

AUDIO_WRITE_ARBITER -- requirements
Module: audio_write_arbiter

---
 rtl/audio_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_audio_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_write_arbiter.sv
// ============================================================================
// Module   : audio_write_arbiter
// Brief    : Four-requester round-robin arbiter that issues single-beat
//            writes (4-bit address, 7-bit data) to an audio parameter slave
//            over separate address, data and response handshakes.
//            Optional macro AUDIO_WRITE_ARBITER_TIMEOUT_EN adds a per-
//            transaction abort after TIMEOUT cycles in SEND plus RESP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_write_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [3:0]  REQ,
   input  logic [15:0] REQ_ADDR,
   input  logic [27:0] REQ_DATA,
   output logic [3:0]  ACK,
   output logic        ERR,
   output logic        BUSY,
   output logic [3:0]  AWADDR,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [6:0]  WDATA,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic        BVALID,
   output logic        BREADY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [1:0]  r_last;
   logic [1:0]  r_gnt;
   logic [3:0]  r_awaddr;
   logic [6:0]  r_wdata;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic [3:0]  r_ack;
   logic        r_busy;
   logic [1:0]  w_gnt_idx;
   logic        w_aw_done;
   logic        w_w_done;
   logic        w_abort;

`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]  r_cnt;
   logic        r_err;

   // Abort on the TIMEOUT-th cycle spent in SEND or RESP.
   assign w_abort = ((r_state == S_SEND) || (r_state == S_RESP)) && (r_cnt == c_TO_LAST);
   assign ERR     = r_err;
`else
   logic        w_unused;

   assign w_unused = (TIMEOUT > 255);
   assign w_abort  = 1'b0;
   assign ERR      = 1'b0;
`endif

   // Round-robin pick: lowest offset after the last grant wins; the last
   // granted requester itself (offset 4) has the lowest priority.
   always_comb begin
      w_gnt_idx = r_last;
      for (int i = 4; i >= 1; i--) begin
         if (REQ[2'(r_last + 2'(i))]) begin
            w_gnt_idx = 2'(r_last + 2'(i));
         end
      end
   end

   // A handshake is complete if it finished earlier or finishes this cycle.
   assign w_aw_done = !r_awvalid || AWREADY;
   assign w_w_done  = !r_wvalid  || WREADY;

   // Transaction sequencer with all bus outputs registered.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= S_IDLE;
         r_last    <= 2'd3;
         r_gnt     <= 2'd0;
         r_awaddr  <= 4'd0;
         r_wdata   <= 7'd0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_ack     <= 4'd0;
         r_busy    <= 1'b0;
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
         r_cnt     <= 8'd0;
         r_err     <= 1'b0;
`endif
      end else begin
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
         if ((r_state == S_SEND) || (r_state == S_RESP)) begin
            r_cnt <= r_cnt + 8'd1;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (|REQ) begin
                  r_gnt     <= w_gnt_idx;
                  r_last    <= w_gnt_idx;
                  r_awaddr  <= REQ_ADDR[4*w_gnt_idx +: 4];
                  r_wdata   <= REQ_DATA[7*w_gnt_idx +: 7];
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_SEND;
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
                  r_cnt     <= 8'd0;
`endif
               end
            end
            S_SEND, S_RESP: begin
               if (w_abort) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_bready  <= 1'b0;
                  r_ack     <= 4'b0001 << r_gnt;
                  r_state   <= S_DONE;
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
                  r_err     <= 1'b1;
`endif
               end else if (r_state == S_SEND) begin
                  if (AWREADY) r_awvalid <= 1'b0;
                  if (WREADY)  r_wvalid  <= 1'b0;
                  if (w_aw_done && w_w_done) begin
                     r_bready <= 1'b1;
                     r_state  <= S_RESP;
                  end
               end else if (BVALID && r_bready) begin
                  r_bready <= 1'b0;
                  r_ack    <= 4'b0001 << r_gnt;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_ack   <= 4'd0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
               r_err   <= 1'b0;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign AWADDR  = r_awaddr;
   assign WDATA   = r_wdata;
   assign AWVALID = r_awvalid;
   assign WVALID  = r_wvalid;
   assign BREADY  = r_bready;
   assign ACK     = r_ack;
   assign BUSY    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_audio_write_arbiter.sv
// ============================================================================
// Module   : tb_audio_write_arbiter
// Brief    : Self-checking bench for audio_write_arbiter: a transaction-level
//            reference model compared every cycle, plus directed scenarios
//            with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_write_arbiter;

   localparam int TO = 10;
`ifdef AUDIO_WRITE_ARBITER_TIMEOUT_EN
   localparam bit TE = 1'b1;
`else
   localparam bit TE = 1'b0;
`endif

   logic        ACLK;
   logic        ARESETn;
   logic [3:0]  REQ;
   logic [15:0] REQ_ADDR;
   logic [27:0] REQ_DATA;
   logic [3:0]  ACK;
   logic        ERR;
   logic        BUSY;
   logic [3:0]  AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [6:0]  WDATA;
   logic        WVALID;
   logic        WREADY;
   logic        BVALID;
   logic        BREADY;

   int checks = 0;
   int errors = 0;
   int n_ack  = 0;

   audio_write_arbiter #(.TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA(REQ_DATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
      .BVALID(BVALID), .BREADY(BREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // phase: 0 idle, 1 address/data phase, 2 response phase, 3 completion
   int m_ph, m_last, m_gnt, m_addr, m_data, m_n, m_ack, m_c;
   bit m_awv, m_wv, m_br, m_err, m_busy, m_found;

   task automatic m_reset();
      m_ph = 0; m_last = 3; m_gnt = 0; m_addr = 0; m_data = 0; m_n = 0;
      m_ack = 0; m_awv = 0; m_wv = 0; m_br = 0; m_err = 0; m_busy = 0;
   endtask

   task automatic m_abort();
      m_awv = 0; m_wv = 0; m_br = 0; m_ack = 1 << m_gnt; m_err = 1; m_ph = 3;
   endtask

   task automatic m_step();
      case (m_ph)
         0: if (REQ != 4'd0) begin
               m_found = 0;
               for (int k = 1; k <= 4; k++) begin
                  m_c = (m_last + k) % 4;
                  if (!m_found && REQ[m_c]) begin
                     m_gnt = m_c;
                     m_found = 1;
                  end
               end
               m_last = m_gnt;
               m_addr = int'((REQ_ADDR >> (4 * m_gnt)) & 16'hF);
               m_data = int'((REQ_DATA >> (7 * m_gnt)) & 28'h7F);
               m_awv = 1; m_wv = 1; m_busy = 1; m_n = 0; m_ph = 1;
            end
         1: begin
               m_n++;
               if (TE && m_n == TO) m_abort();
               else begin
                  if (AWREADY) m_awv = 0;
                  if (WREADY)  m_wv  = 0;
                  if (!m_awv && !m_wv) begin m_br = 1; m_ph = 2; end
               end
            end
         2: begin
               m_n++;
               if (TE && m_n == TO) m_abort();
               else if (BVALID) begin m_br = 0; m_ack = 1 << m_gnt; m_ph = 3; end
            end
         default: begin
               m_ack = 0; m_err = 0; m_busy = 0; m_ph = 0;
            end
      endcase
   endtask

   // Compare every cycle at the falling edge, then advance the model with
   // the inputs the DUT will sample at the next rising edge.
   always @(negedge ACLK) begin
      if (!ARESETn) m_reset();
      check("cyc_ACK",     int'(ACK),     m_ack);
      check("cyc_ERR",     int'(ERR),     int'(m_err));
      check("cyc_BUSY",    int'(BUSY),    int'(m_busy));
      check("cyc_AWADDR",  int'(AWADDR),  m_addr);
      check("cyc_WDATA",   int'(WDATA),   m_data);
      check("cyc_AWVALID", int'(AWVALID), int'(m_awv));
      check("cyc_WVALID",  int'(WVALID),  int'(m_wv));
      check("cyc_BREADY",  int'(BREADY),  int'(m_br));
      if (ACK != 4'd0) n_ack++;
      if (ARESETn) m_step();
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge ACLK);
      #2;
   endtask

   task automatic wait_ack(input int budget, output logic [3:0] a, output logic e,
                           output int cyc);
      a = 4'd0; e = 1'b0; cyc = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (ACK != 4'd0) begin
            a = ACK; e = ERR; cyc = i;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ack_wait actual=no ACK in %0d cycles required=ACK pulse at %0t",
               budget, $time);
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      tick();
      ARESETn = 1'b1;
      tick();
   endtask

   logic [3:0] a;
   logic       e;
   int         cyc, snap;
   int         rr_exp [5] = '{1, 2, 4, 8, 1};

   initial begin
      ARESETn = 1'b0; REQ = 4'd0; REQ_ADDR = 16'd0; REQ_DATA = 28'd0;
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      repeat (2) tick();
      check("rst_BUSY",    int'(BUSY), 0);
      check("rst_ACK",     int'(ACK), 0);
      check("rst_AWVALID", int'(AWVALID), 0);
      check("rst_BREADY",  int'(BREADY), 0);
      ARESETn = 1'b1;
      tick();

      // Single write from requester 0, slave always ready.
      REQ_ADDR = 16'h0009; REQ_DATA = 28'h0000040;
      AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
      REQ = 4'b0001;
      snap = n_ack;
      tick();
      check("t1_AWVALID", int'(AWVALID), 1);
      check("t1_WVALID",  int'(WVALID), 1);
      check("t1_AWADDR",  int'(AWADDR), 9);
      check("t1_WDATA",   int'(WDATA), 'h40);
      wait_ack(10, a, e, cyc);
      check("t1_ACK", int'(a), 1);
      check("t1_ERR", int'(e), 0);
      tick();
      REQ = 4'd0;
      repeat (3) tick();
      check("t1_ack_pulses", n_ack - snap, 1);

      // Round robin with all requesters held high.
      do_reset();
      REQ_ADDR = 16'hB7A5; REQ_DATA = 28'h9A3C5E1;
      REQ = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(10, a, e, cyc);
         check($sformatf("rr_ack_%0d", k), int'(a), rr_exp[k]);
      end
      tick();
      REQ = 4'd0;
      repeat (3) tick();

      // Address handshake in SEND cycle 1, data handshake in cycle 3.
      do_reset();
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1;
      REQ = 4'b0010;
      tick();
      AWREADY = 1'b1;
      check("t3_c1_AWVALID", int'(AWVALID), 1);
      tick();
      AWREADY = 1'b0;
      check("t3_c2_AWVALID", int'(AWVALID), 0);
      check("t3_c2_WVALID",  int'(WVALID), 1);
      check("t3_c2_BREADY",  int'(BREADY), 0);
      tick();
      WREADY = 1'b1;
      check("t3_c3_BREADY", int'(BREADY), 0);
      tick();
      WREADY = 1'b0;
      check("t3_c4_WVALID", int'(WVALID), 0);
      check("t3_c4_BREADY", int'(BREADY), 1);
      wait_ack(10, a, e, cyc);
      check("t3_ACK", int'(a), 2);
      tick();
      REQ = 4'd0;
      repeat (2) tick();

      // Reset during the response phase of requester 2.
      do_reset();
      REQ_ADDR = 16'h0C00; REQ_DATA = 28'h0155000;
      AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
      REQ = 4'b0100;
      tick();
      tick();
      check("t4_BREADY_resp", int'(BREADY), 1);
      snap = n_ack;
      ARESETn = 1'b0;
      #1;
      check("t4_rst_BREADY", int'(BREADY), 0);
      check("t4_rst_BUSY",   int'(BUSY), 0);
      check("t4_rst_AWADDR", int'(AWADDR), 0);
      check("t4_rst_WDATA",  int'(WDATA), 0);
      check("t4_rst_ACK",    int'(ACK), 0);
      repeat (2) tick();
      ARESETn = 1'b1;
      check("t4_no_ack", n_ack - snap, 0);
      BVALID = 1'b1;
      wait_ack(10, a, e, cyc);
      check("t4_ACK", int'(a), 4);
      check("t4_ERR", int'(e), 0);
      tick();
      REQ = 4'd0;
      repeat (2) tick();

      // Response never arrives.
      do_reset();
      AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
      REQ = 4'b0001;
      snap = n_ack;
      if (TE) begin
         wait_ack(20, a, e, cyc);
         check("t5_ACK", int'(a), 1);
         check("t5_ERR", int'(e), 1);
         check("t5_abort_cycle", cyc, 10);
         check("t5_BREADY", int'(BREADY), 0);
         tick();
         REQ = 4'd0;
      end else begin
         repeat (30) tick();
         check("t5_BREADY_held", int'(BREADY), 1);
         check("t5_ERR", int'(ERR), 0);
         check("t5_no_ack", n_ack - snap, 0);
         REQ = 4'd0;
         do_reset();
      end
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
